bullet_pool_ctrl: RTL and testbench

Controller for the player's bullets in the meteorite shooter. It owns a fixed pool of bullet slots on the 40x30 game grid. It allocates a slot on each shoot-button press, advances all live bullets upward on a shared speed tick, and frees slots on top-of-screen exit or on a meteor hit. It sits between the ship/button logic and the VGA pixel pipeline and drives a single merged bullet draw flag.

---
 rtl/bullet_pool_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bullet_pool_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool_ctrl.sv
// Player bullet pool: allocates slots on shoot presses, moves live bullets up on a
// shared speed tick, frees them on top exit or hit. Optional feature macro: BULLET_COOLDOWN_EN.
module bullet_pool_ctrl #(
    parameter int unsigned c_GameWidth  = 40,
    parameter int unsigned c_GameHeight = 30,
    parameter int unsigned c_NumBull    = 4,
    parameter int unsigned c_BullSpeed  = 1250000,
    parameter int unsigned c_ShipRow    = 28,
    parameter int unsigned c_Cooldown   = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_GameActive,
    input  logic                   i_Shoot,
    input  logic [5:0]             i_ShipX,
    input  logic                   i_HitValid,
    input  logic [2:0]             i_HitSlot,
    input  logic [5:0]             i_ColCountDiv,
    input  logic [5:0]             i_RowCountDiv,
    output logic                   o_DrawBull,
    output logic [c_NumBull-1:0]   o_ActiveMask,
    output logic [6*c_NumBull-1:0] o_BullXFlat,
    output logic [6*c_NumBull-1:0] o_BullYFlat,
    output logic                   o_FireAccept,
    output logic                   o_FireDrop
);

    localparam int unsigned CW       = 6;
    localparam int unsigned MAX_X    = c_GameWidth - 1;
    localparam int unsigned SPAWN_Y  = (c_ShipRow < c_GameHeight) ? c_ShipRow : c_GameHeight - 1;
    localparam int unsigned TICK_MAX = c_BullSpeed - 1;

    if (c_NumBull < 1 || c_NumBull > 8 || c_Cooldown > 255) begin : g_bad_cfg
        $error("bullet_pool_ctrl: unsupported parameter set");
    end

    logic                 shoot_q;
    logic [31:0]          tick_cnt_q, tick_cnt_d;
    logic [c_NumBull-1:0] mask_d;
    logic [CW-1:0]        bx_q [c_NumBull];
    logic [CW-1:0]        bx_d [c_NumBull];
    logic [CW-1:0]        by_q [c_NumBull];
    logic [CW-1:0]        by_d [c_NumBull];
    logic                 accept_d, drop_d, draw_d;
    logic                 press, tick, hit_ok, have_free, cd_ready;
    logic [2:0]           free_idx;
    logic [6:0]           spawn_sum;
    logic [CW-1:0]        spawn_x;

`ifdef BULLET_COOLDOWN_EN
    localparam int unsigned CD_W = (c_Cooldown < 2) ? 1 : $clog2(c_Cooldown + 1);

    // Ticks still to elapse before the next fire is allowed; 0 means ready.
    logic [CD_W-1:0] cd_q, cd_d;

    assign cd_ready = (cd_q == '0);

    always_comb begin
        cd_d = cd_q;
        if (!i_GameActive)
            cd_d = '0;
        else if (accept_d)
            cd_d = CD_W'(c_Cooldown);
        else if (tick && cd_q != '0)
            cd_d = cd_q - CD_W'(1);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) cd_q <= '0;
        else       cd_q <= cd_d;
    end
`else
    assign cd_ready = 1'b1;
`endif

    // Press detect, tick, spawn position and lowest free slot.
    always_comb begin
        press     = i_Shoot & ~shoot_q;
        tick      = (tick_cnt_q == 32'(TICK_MAX));
        hit_ok    = i_HitValid && (32'(i_HitSlot) < c_NumBull);
        spawn_sum = 7'(i_ShipX) + 7'd2;
        spawn_x   = (spawn_sum > 7'(MAX_X)) ? CW'(MAX_X) : spawn_sum[CW-1:0];
        have_free = 1'b0;
        free_idx  = '0;
        for (int k = int'(c_NumBull) - 1; k >= 0; k--) begin
            if (!o_ActiveMask[k]) begin
                have_free = 1'b1;
                free_idx  = 3'(k);
            end
        end
    end

    // Pool next state: hits override tick moves; allocation uses the pre-free mask.
    always_comb begin
        mask_d     = o_ActiveMask;
        bx_d       = bx_q;
        by_d       = by_q;
        accept_d   = 1'b0;
        drop_d     = 1'b0;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
        if (!i_GameActive) begin
            mask_d     = '0;
            tick_cnt_d = '0;
        end else begin
            for (int k = 0; k < int'(c_NumBull); k++) begin
                if (hit_ok && i_HitSlot == 3'(k)) begin
                    mask_d[k] = 1'b0;
                end else if (tick && o_ActiveMask[k]) begin
                    if (by_q[k] == '0) mask_d[k] = 1'b0;
                    else               by_d[k]   = by_q[k] - CW'(1);
                end
            end
            if (press) begin
                if (have_free && cd_ready) begin
                    accept_d = 1'b1;
                    for (int k = 0; k < int'(c_NumBull); k++) begin
                        if (free_idx == 3'(k)) begin
                            mask_d[k] = 1'b1;
                            bx_d[k]   = spawn_x;
                            by_d[k]   = CW'(SPAWN_Y);
                        end
                    end
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    // Merged draw flag for the currently scanned cell.
    always_comb begin
        draw_d = 1'b0;
        for (int k = 0; k < int'(c_NumBull); k++) begin
            if (o_ActiveMask[k] && bx_q[k] == i_ColCountDiv && by_q[k] == i_RowCountDiv)
                draw_d = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(c_NumBull); k++) begin
            o_BullXFlat[6*k +: 6] = bx_q[k];
            o_BullYFlat[6*k +: 6] = by_q[k];
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            shoot_q      <= 1'b0;
            tick_cnt_q   <= '0;
            o_ActiveMask <= '0;
            o_FireAccept <= 1'b0;
            o_FireDrop   <= 1'b0;
            o_DrawBull   <= 1'b0;
            for (int k = 0; k < int'(c_NumBull); k++) begin
                bx_q[k] <= '0;
                by_q[k] <= '0;
            end
        end else begin
            shoot_q      <= i_Shoot;
            tick_cnt_q   <= tick_cnt_d;
            o_ActiveMask <= mask_d;
            o_FireAccept <= accept_d;
            o_FireDrop   <= drop_d;
            o_DrawBull   <= draw_d;
            for (int k = 0; k < int'(c_NumBull); k++) begin
                bx_q[k] <= bx_d[k];
                by_q[k] <= by_d[k];
            end
        end
    end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Self-checking bench for bullet_pool_ctrl: vector table with scoreboard plus
// directed sequences for ticks, hits on tick cycles, clamping, draw and reset.
module tb_bullet_pool_ctrl;

    localparam int S  = 16;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ga, shoot, hv;
    logic [5:0]    shipx, col, row;
    logic [2:0]    hs;
    logic          draw, acc, drop;
    logic [NB-1:0] mask;
    logic [6*NB-1:0] xflat, yflat;

    int pass_cnt = 0;
    int total    = 0;

    bullet_pool_ctrl #(
        .c_GameWidth(40), .c_GameHeight(30), .c_NumBull(NB),
        .c_BullSpeed(S), .c_ShipRow(28), .c_Cooldown(3)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_GameActive(ga), .i_Shoot(shoot),
        .i_ShipX(shipx), .i_HitValid(hv), .i_HitSlot(hs),
        .i_ColCountDiv(col), .i_RowCountDiv(row),
        .o_DrawBull(draw), .o_ActiveMask(mask),
        .o_BullXFlat(xflat), .o_BullYFlat(yflat),
        .o_FireAccept(acc), .o_FireDrop(drop)
    );

    always #5 clk = ~clk;

    // Reference tick timing: counter 0..S-1, held at 0 while the game is inactive.
    int tcnt  = 0;
    int ticks = 0;
    always @(posedge clk or posedge rst) begin
        if (rst)             tcnt <= 0;
        else if (!ga)        tcnt <= 0;
        else if (tcnt == S-1) begin
            tcnt  <= 0;
            ticks <= ticks + 1;
        end else             tcnt <= tcnt + 1;
    end

    typedef struct {
        logic       ga, sh;
        logic [5:0] x;
        logic       hv;
        logic [2:0] hs;
        logic       acc, drop;
        logic [3:0] mask;
    } vec_t;

    typedef struct {
        int         idx;
        logic       acc, drop;
        logic [3:0] mask;
    } exp_t;

    vec_t tbl [21];
    exp_t exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] xof(input int k);
        return xflat[6*k +: 6];
    endfunction

    function automatic logic [5:0] yof(input int k);
        return yflat[6*k +: 6];
    endfunction

    task automatic clear_pool();
        ga = 1'b0; shoot = 1'b0; hv = 1'b0;
        cyc(); cyc();
        ga = 1'b1;
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = ticks;
        for (int i = 0; i < S*(n+2) && ticks < t0 + n; i++) cyc();
        if (ticks < t0 + n) begin
            total++;
            $display("FAIL tick_wait: got %0d ticks expected %0d", ticks - t0, n);
        end
    endtask

    initial begin
        exp_t e;
        int   n_acc, n_drop;

        tbl[0]  = '{1'b1, 1'b0, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0001};
        tbl[2]  = '{1'b1, 1'b0, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001};
        tbl[3]  = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0011};
        tbl[4]  = '{1'b1, 1'b0, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0011};
        tbl[5]  = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0111};
        tbl[6]  = '{1'b1, 1'b0, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0111};
        tbl[7]  = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b1, 1'b0, 4'b1111};
        tbl[8]  = '{1'b1, 1'b0, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b1111};
        tbl[9]  = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b0, 1'b1, 4'b1111};
        tbl[10] = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b1111};
        tbl[11] = '{1'b1, 1'b0, 6'd10, 1'b1, 3'd1, 1'b0, 1'b0, 4'b1101};
        tbl[12] = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b1, 1'b0, 4'b1111};
        tbl[13] = '{1'b1, 1'b0, 6'd10, 1'b1, 3'd5, 1'b0, 1'b0, 4'b1111};
        tbl[14] = '{1'b0, 1'b0, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000};
        tbl[15] = '{1'b0, 1'b1, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000};
        tbl[16] = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000};
        tbl[17] = '{1'b1, 1'b0, 6'd10, 1'b1, 3'd0, 1'b0, 1'b0, 4'b0000};
        tbl[18] = '{1'b1, 1'b1, 6'd10, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0001};
        tbl[19] = '{1'b1, 1'b0, 6'd10, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001};
        tbl[20] = '{1'b1, 1'b0, 6'd10, 1'b1, 3'd0, 1'b0, 1'b0, 4'b0000};

        rst = 1'b1; ga = 1'b0; shoot = 1'b0; shipx = 6'd10;
        hv = 1'b0; hs = 3'd0; col = 6'd0; row = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mask", 32'(mask), 0);
        chk("rst_x", 32'(xflat), 0);
        chk("rst_y", 32'(yflat), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_draw", 32'(draw), 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            ga = tbl[i].ga; shoot = tbl[i].sh; shipx = tbl[i].x;
            hv = tbl[i].hv; hs = tbl[i].hs;
            exp_q.push_back('{i, tbl[i].acc, tbl[i].drop, tbl[i].mask});
            cyc();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_acc", e.idx), 32'(acc), 32'(e.acc));
            chk($sformatf("vec%0d_drop", e.idx), 32'(drop), 32'(e.drop));
            chk($sformatf("vec%0d_mask", e.idx), 32'(mask), 32'(e.mask));
        end
        hv = 1'b0;

        // Spawn position and flight to the top of the screen.
        clear_pool();
        shipx = 6'd10; shoot = 1'b1;
        cyc();
        shoot = 1'b0;
        chk("fly_acc", 32'(acc), 1);
        chk("fly_mask", 32'(mask), 32'b0001);
        chk("fly_x", 32'(xof(0)), 12);
        chk("fly_y", 32'(yof(0)), 28);
        wait_ticks(1);
        chk("fly_y_t1", 32'(yof(0)), 27);
        wait_ticks(27);
        chk("fly_y_t28", 32'(yof(0)), 0);
        chk("fly_live_t28", 32'(mask[0]), 1);
        wait_ticks(1);
        chk("fly_freed", 32'(mask[0]), 0);
        chk("fly_y_kept", 32'(yof(0)), 0);

        // Hit on a tick cycle: hit wins, no decrement, slot reused.
        clear_pool();
        shoot = 1'b1; cyc();
        shoot = 1'b0; cyc();
        shoot = 1'b1; cyc();
        shoot = 1'b0;
        chk("hit_pre_mask", 32'(mask), 32'b0011);
        for (int i = 0; i < 2*S && tcnt != S-1; i++) cyc();
        hv = 1'b1; hs = 3'd1;
        cyc();
        hv = 1'b0;
        chk("hit_mask", 32'(mask), 32'b0001);
        chk("hit_y1", 32'(yof(1)), 28);
        chk("hit_y0", 32'(yof(0)), 27);
        shoot = 1'b1; cyc();
        shoot = 1'b0;
        chk("hit_reuse_acc", 32'(acc), 1);
        chk("hit_reuse_mask", 32'(mask), 32'b0011);
        chk("hit_reuse_y1", 32'(yof(1)), 28);

        // Clamp at right edge and held button.
        clear_pool();
        shipx = 6'd39; shoot = 1'b1;
        cyc();
        chk("clamp_acc", 32'(acc), 1);
        chk("clamp_x", 32'(xof(0)), 39);
        n_acc = 0; n_drop = 0;
        for (int i = 0; i < 999; i++) begin
            cyc();
            if (acc)  n_acc++;
            if (drop) n_drop++;
        end
        shoot = 1'b0;
        chk("hold_extra_acc", 32'(n_acc), 0);
        chk("hold_drop", 32'(n_drop), 0);

        // Draw at X=5,Y=20 and its neighbours.
        clear_pool();
        shipx = 6'd3; shoot = 1'b1;
        cyc();
        shoot = 1'b0;
        wait_ticks(8);
        chk("draw_x", 32'(xof(0)), 5);
        chk("draw_y", 32'(yof(0)), 20);
        col = 6'd5; row = 6'd20;
        cyc();
        col = 6'd0; row = 6'd0;
        chk("draw_hit", 32'(draw), 1);
        cyc();
        chk("draw_off", 32'(draw), 0);
        for (int i = 0; i < 4; i++) begin
            int nc [4] = '{4, 6, 5, 5};
            int nr [4] = '{20, 20, 19, 21};
            col = 6'(nc[i]); row = 6'(nr[i]);
            cyc();
            chk($sformatf("draw_nb%0d", i), 32'(draw), 0);
        end
        col = 6'd5; row = 6'd20; ga = 1'b0;
        cyc();
        chk("draw_ga_mask", 32'(mask), 0);
        cyc();
        chk("draw_ga_draw", 32'(draw), 0);
        ga = 1'b1;

        // Asynchronous reset mid-flight.
        clear_pool();
        shipx = 6'd10; shoot = 1'b1;
        cyc();
        shoot = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("mrst_mask", 32'(mask), 0);
        chk("mrst_x", 32'(xflat), 0);
        chk("mrst_y", 32'(yflat), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        chk("mrst_after", 32'(mask), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
